// File: rtl/vga_pkg.sv
// Shared constants, types and helpers for the VGA scanout engine.
// Default timing is 640x480@60; RGB332 pixels unpack into a 3/3/2 colour struct.
package vga_pkg;

   localparam int H_ACTIVE_DEF = 640;
   localparam int H_FP_DEF     = 16;
   localparam int H_SYNC_DEF   = 96;
   localparam int H_BP_DEF     = 48;
   localparam int V_ACTIVE_DEF = 480;
   localparam int V_FP_DEF     = 10;
   localparam int V_SYNC_DEF   = 2;
   localparam int V_BP_DEF     = 33;

   localparam logic [7:0] BORDER_DEF = 8'h00;

   // Control stages between the counters and the output register; matches RAM read latency.
   localparam int PIPE_STAGES = 2;

   typedef struct packed {
      logic [2:0] r;
      logic [2:0] g;
      logic [1:0] b;
   } rgb_t;

   typedef struct packed {
      logic hsync_n;
      logic vsync_n;
      logic active;
      logic in_window;
      logic frame_start;
   } ctrl_t;

   localparam ctrl_t CTRL_IDLE = '{hsync_n: 1'b1, vsync_n: 1'b1, active: 1'b0,
                                   in_window: 1'b0, frame_start: 1'b0};

   function automatic int line_total(input int act, input int fp, input int sync, input int bp);
      return act + fp + sync + bp;
   endfunction

   function automatic rgb_t unpack_rgb332(input logic [7:0] px);
      rgb_t c;
      c.r = px[7:5];
      c.g = px[4:2];
      c.b = px[1:0];
      return c;
   endfunction

endpackage

// File: rtl/vga_timing.sv
// Free-running horizontal/vertical counters with raw (unregistered) sync,
// active-video and frame-start flags decoded from the current counter state.
module vga_timing
   import vga_pkg::*;
#(
   parameter int H_ACTIVE = H_ACTIVE_DEF,
   parameter int H_FP     = H_FP_DEF,
   parameter int H_SYNC   = H_SYNC_DEF,
   parameter int H_BP     = H_BP_DEF,
   parameter int V_ACTIVE = V_ACTIVE_DEF,
   parameter int V_FP     = V_FP_DEF,
   parameter int V_SYNC   = V_SYNC_DEF,
   parameter int V_BP     = V_BP_DEF,
   parameter int HW       = 10,
   parameter int VW       = 10
) (
   input  logic          clk_i,
   input  logic          rst_ni,
   output logic [HW-1:0] h_cnt_o,
   output logic [VW-1:0] v_cnt_o,
   output logic          hsync_n_o,
   output logic          vsync_n_o,
   output logic          active_o,
   output logic          frame_start_o
);

   localparam int H_TOTAL = line_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
   localparam int V_TOTAL = line_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

   logic [HW-1:0] h_cnt_q, h_cnt_d;
   logic [VW-1:0] v_cnt_q, v_cnt_d;

   always_comb begin
      h_cnt_d = h_cnt_q + 1'b1;
      v_cnt_d = v_cnt_q;
      if (h_cnt_q == HW'(H_TOTAL - 1)) begin
         h_cnt_d = '0;
         v_cnt_d = (v_cnt_q == VW'(V_TOTAL - 1)) ? '0 : v_cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         h_cnt_q <= '0;
         v_cnt_q <= '0;
      end else begin
         h_cnt_q <= h_cnt_d;
         v_cnt_q <= v_cnt_d;
      end
   end

   assign h_cnt_o       = h_cnt_q;
   assign v_cnt_o       = v_cnt_q;
   assign active_o      = (h_cnt_q < HW'(H_ACTIVE)) && (v_cnt_q < VW'(V_ACTIVE));
   assign hsync_n_o     = !((h_cnt_q >= HW'(H_ACTIVE + H_FP)) &&
                            (h_cnt_q <  HW'(H_ACTIVE + H_FP + H_SYNC)));
   // Vertical sync spans whole lines, so it only depends on the line counter.
   assign vsync_n_o     = !((v_cnt_q >= VW'(V_ACTIVE + V_FP)) &&
                            (v_cnt_q <  VW'(V_ACTIVE + V_FP + V_SYNC)));
   assign frame_start_o = (h_cnt_q == '0) && (v_cnt_q == '0);

endmodule

// File: rtl/vga_scanout.sv
// Scanout engine: maps screen position to frame-buffer address, delays control
// alongside the two-cycle RAM read, and registers colour, syncs and data-enable.
module vga_scanout
   import vga_pkg::*;
#(
   parameter int         addr_width  = 10,
   parameter int         data_width  = 8,
   parameter int         FB_W_LOG2   = 5,
   parameter int         FB_H_LOG2   = 5,
   parameter int         SCALE_SHIFT = 4,
   parameter int         H_ACTIVE    = H_ACTIVE_DEF,
   parameter int         H_FP        = H_FP_DEF,
   parameter int         H_SYNC      = H_SYNC_DEF,
   parameter int         H_BP        = H_BP_DEF,
   parameter int         V_ACTIVE    = V_ACTIVE_DEF,
   parameter int         V_FP        = V_FP_DEF,
   parameter int         V_SYNC      = V_SYNC_DEF,
   parameter int         V_BP        = V_BP_DEF,
   parameter logic [7:0] BORDER      = BORDER_DEF
) (
   input  logic                  clk,
   input  logic                  rst_n,
   output logic [addr_width-1:0] read_address,
   input  logic [data_width-1:0] q,
   input  logic                  blank,
   output logic                  hsync_n,
   output logic                  vsync_n,
   output logic                  de,
   output logic [2:0]            red,
   output logic [2:0]            green,
   output logic [1:0]            blue,
   output logic                  frame_start
);

   localparam int HW = $clog2(line_total(H_ACTIVE, H_FP, H_SYNC, H_BP));
   localparam int VW = $clog2(line_total(V_ACTIVE, V_FP, V_SYNC, V_BP));

   logic [HW-1:0] h_cnt;
   logic [VW-1:0] v_cnt;
   logic          raw_hsync_n, raw_vsync_n, raw_active, raw_frame_start;

   vga_timing #(
      .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
      .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
      .HW(HW), .VW(VW)
   ) u_timing (
      .clk_i         (clk),
      .rst_ni        (rst_n),
      .h_cnt_o       (h_cnt),
      .v_cnt_o       (v_cnt),
      .hsync_n_o     (raw_hsync_n),
      .vsync_n_o     (raw_vsync_n),
      .active_o      (raw_active),
      .frame_start_o (raw_frame_start)
   );

   logic [HW-1:0] fx;
   logic [VW-1:0] fy;
   logic          in_window;

   assign fx           = h_cnt >> SCALE_SHIFT;
   assign fy           = v_cnt >> SCALE_SHIFT;
   assign in_window    = raw_active && ((fx >> FB_W_LOG2) == '0) && ((fy >> FB_H_LOG2) == '0);
   // Outside the window the truncated coordinates still give a defined address.
   assign read_address = {fy[FB_H_LOG2-1:0], fx[FB_W_LOG2-1:0]};

   ctrl_t stage_in;
   ctrl_t pipe_in [PIPE_STAGES];
   ctrl_t pipe_q  [PIPE_STAGES];

   assign stage_in = '{hsync_n: raw_hsync_n, vsync_n: raw_vsync_n, active: raw_active,
                       in_window: in_window, frame_start: raw_frame_start};

   genvar gi;
   generate
      for (gi = 0; gi < PIPE_STAGES; gi++) begin : g_pipe
         if (gi == 0) begin : g_first
            assign pipe_in[gi] = stage_in;
         end else begin : g_next
            assign pipe_in[gi] = pipe_q[gi-1];
         end
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) pipe_q[gi] <= CTRL_IDLE;
            else        pipe_q[gi] <= pipe_in[gi];
         end
      end
   endgenerate

   ctrl_t last;
   assign last = pipe_q[PIPE_STAGES-1];

   rgb_t rgb_d, rgb_q;
   logic hsync_n_q, vsync_n_q, de_q, frame_start_q;

   // q arrives in the same cycle as the last control stage, so both feed the output register.
   always_comb begin
      rgb_d = '0;
      if (last.active && !blank)
         rgb_d = last.in_window ? unpack_rgb332(q[7:0]) : unpack_rgb332(BORDER);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hsync_n_q     <= 1'b1;
         vsync_n_q     <= 1'b1;
         de_q          <= 1'b0;
         frame_start_q <= 1'b0;
         rgb_q         <= '0;
      end else begin
         hsync_n_q     <= last.hsync_n;
         vsync_n_q     <= last.vsync_n;
         de_q          <= last.active;
         frame_start_q <= last.frame_start;
         rgb_q         <= rgb_d;
      end
   end

   assign hsync_n     = hsync_n_q;
   assign vsync_n     = vsync_n_q;
   assign de          = de_q;
   assign frame_start = frame_start_q;
   assign red         = rgb_q.r;
   assign green       = rgb_q.g;
   assign blue        = rgb_q.b;

endmodule

// File: tb/tb_vga_scanout.sv
// Bench for vga_scanout: pixel-index model of the raster checked every cycle,
// plus directed literal checks of latency, mapping, border, blanking and reset.
module tb_vga_scanout;

   localparam int HT   = 800;
   localparam int VACT = 52;
   localparam int VT   = 60;   // 52 active + 2 fp + 2 sync + 4 bp, short frame to bound run time

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       blank = 1'b0;
   logic [9:0] read_address;
   logic [7:0] q;
   logic       hsync_n, vsync_n, de, frame_start;
   logic [2:0] red, green;
   logic [1:0] blue;

   vga_scanout #(
      .V_ACTIVE(52), .V_FP(2), .V_SYNC(2), .V_BP(4), .BORDER(8'hE0)
   ) dut (
      .clk(clk), .rst_n(rst_n), .read_address(read_address), .q(q), .blank(blank),
      .hsync_n(hsync_n), .vsync_n(vsync_n), .de(de),
      .red(red), .green(green), .blue(blue), .frame_start(frame_start)
   );

   always #5 clk = ~clk;

   // Two-cycle RAM model
   logic [7:0] mem [1024];
   logic [7:0] ram_s1 = 8'h00;
   logic [7:0] ram_q  = 8'h00;
   always @(posedge clk) begin
      ram_s1 <= mem[read_address];
      ram_q  <= ram_s1;
   end
   assign q = ram_q;

   int edge_cnt = 0;
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) edge_cnt <= 0;
      else        edge_cnt <= edge_cnt + 1;
   end

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (edge %0d)", name, act, exp, edge_cnt);
      end
   endtask

   task automatic goto_edge(input int k);
      while (edge_cnt < k) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Raster measurements
   int de_run, de_lines, hs_run, hs_last_fall, vs_run, vs_pulses;
   logic de_prev, de_on, hs_prev, hs_on, hs_fall_valid, vs_prev, vs_on;
   initial begin
      de_lines = 0; vs_pulses = 0;
      de_prev = 0; de_on = 0; hs_prev = 0; hs_on = 0; hs_fall_valid = 0; vs_prev = 0; vs_on = 0;
      de_run = 0; hs_run = 0; vs_run = 0; hs_last_fall = 0;
   end

   // Per-cycle model: after k edges the counters hold pixel k; outputs show pixel k-3.
   always @(posedge clk) begin
      logic       b;
      int         k, p, h, v, ch, cv;
      logic       e_hs, e_vs, e_de, e_fs;
      logic [7:0] e_rgb;
      logic [9:0] e_addr;
      b = blank;
      #1;
      k = edge_cnt;
      e_hs = 1'b1; e_vs = 1'b1; e_de = 1'b0; e_fs = 1'b0; e_rgb = 8'h00; e_addr = 10'd0;
      if (rst_n) begin
         ch = k % HT;
         cv = (k / HT) % VT;
         e_addr = 10'(((cv / 16) % 32) * 32 + (ch / 16) % 32);
         if (k >= 3) begin
            p = k - 3;
            h = p % HT;
            v = (p / HT) % VT;
            e_de = (h < 640) && (v < VACT);
            e_hs = !(h >= 656 && h < 752);
            e_vs = !(v >= 54 && v < 56);
            e_fs = (h == 0) && (v == 0);
            if (e_de && !b)
               e_rgb = (h < 512 && v < 512) ? mem[(v / 16) * 32 + h / 16] : 8'hE0;
         end
      end
      n_checks++;
      if ({hsync_n, vsync_n, de, frame_start, red, green, blue, read_address} !==
          {e_hs, e_vs, e_de, e_fs, e_rgb, e_addr}) begin
         n_fail++;
         $display("FAIL raster edge=%0d: got hs=%b vs=%b de=%b fs=%b rgb=%02h addr=%0d, expected hs=%b vs=%b de=%b fs=%b rgb=%02h addr=%0d",
                  k, hsync_n, vsync_n, de, frame_start, {red, green, blue}, read_address,
                  e_hs, e_vs, e_de, e_fs, e_rgb, e_addr);
      end

      if (!rst_n) begin
         de_prev = 0; de_on = 0; hs_prev = 0; hs_on = 0; hs_fall_valid = 0; vs_prev = 0; vs_on = 0;
      end else begin
         if (de) begin
            if (!de_prev) begin de_on = 1; de_run = 0; end
            de_run++;
         end else if (de_prev && de_on) begin
            check("de_len", de_run, 640);
            de_lines++;
            de_on = 0;
         end
         de_prev = de;

         if (!hsync_n && !hs_prev) begin
            if (hs_fall_valid) check("hs_period", k - hs_last_fall, HT);
            hs_last_fall = k; hs_fall_valid = 1; hs_on = 1; hs_run = 0;
         end
         if (!hsync_n) hs_run++;
         else if (hs_prev && hs_on) begin
            check("hs_low", hs_run, 96);
            hs_on = 0;
         end
         hs_prev = !hsync_n;

         if (!vsync_n && !vs_prev) begin vs_on = 1; vs_run = 0; end
         if (!vsync_n) vs_run++;
         else if (vs_prev && vs_on) begin
            check("vs_low", vs_run, 1600);
            vs_pulses++;
            vs_on = 0;
         end
         vs_prev = !vsync_n;
      end
   end

   initial begin
      for (int i = 0; i < 1024; i++) mem[i] = 8'(i);
      mem[0] = 8'hFF;

      repeat (3) @(posedge clk);
      #1;
      check("reset_state", {hsync_n, vsync_n, de, frame_start, red, green, blue}, 12'hC00);
      @(negedge clk) rst_n = 1'b1;

      goto_edge(1);    check("de_edge1", de, 0);
      goto_edge(2);    check("fs_edge2", frame_start, 0);
      goto_edge(3);
      check("first_pixel", {de, frame_start, red, green, blue}, {2'b11, 3'd7, 3'd7, 2'd3});
      goto_edge(4);    check("fs_single", frame_start, 0);

      goto_edge(514);  check("x511_mem31", {red, green, blue}, {3'd0, 3'd7, 2'd3});
      goto_edge(515);  check("x512_border", {red, green, blue}, {3'd7, 3'd0, 2'd0});

      goto_edge(2417); check("addr_17_3", read_address, 1);
      goto_edge(2420); check("rgb_17_3", {red, green, blue}, {3'd0, 3'd0, 2'd1});

      // Blank pixels 200..209 of line 5
      goto_edge(4202); blank = 1'b1;
      goto_edge(4205); check("blank_active", {de, hsync_n, red, green, blue}, {2'b11, 8'h00});
      goto_edge(4212); blank = 1'b0;
      goto_edge(4213); check("unblank", {red, green, blue}, 8'h0D);

      // Blank across the horizontal porch/sync of line 6
      goto_edge(5462); blank = 1'b1;
      goto_edge(5503); check("blank_porch_sync", {hsync_n, de}, 2'b00);
      goto_edge(5560); check("blank_porch_bp", {hsync_n, de}, 2'b10);
      goto_edge(5562); blank = 1'b0;

      // Mid-frame reset at line 10, pixel 300
      goto_edge(8300);
      check("pre_reset_de", de, 1);
      #1 rst_n = 1'b0;
      #1 check("reset_async", {hsync_n, vsync_n, de, frame_start, red, green, blue, read_address},
               {12'hC00, 10'd0});
      repeat (2) @(posedge clk);
      @(negedge clk) rst_n = 1'b1;
      goto_edge(2);    check("restart_edge2", {de, frame_start}, 2'b00);
      goto_edge(3);
      check("restart_fs", {de, frame_start, red, green, blue}, {2'b11, 8'hFF});

      goto_edge(40100); check("addr_100_50", read_address, 102);
      goto_edge(40103); check("rgb_100_50", {red, green, blue}, {3'd3, 3'd1, 2'd2});

      goto_edge(48003); check("frame2_fs", {de, frame_start}, 2'b11);
      goto_edge(48010);
      check("de_lines", de_lines, 62);
      check("vs_pulses", vs_pulses, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/vga_scanout.md
# vga_scanout

Pixel-clock-domain scanout engine that consumes the dual-clock frame-buffer RAM read port. It generates 640x480@60 VGA timing, drives the RAM read address for each visible pixel, absorbs the RAM's two-cycle read latency, and presents aligned RGB, sync and data-enable to the DAC/pins. A 32x32 frame buffer is displayed magnified by 2^SCALE_SHIFT. Pixels outside the buffer window show a border colour.

## Interface
- addr_width, 10: RAM address width. Must equal FB_W_LOG2 + FB_H_LOG2.
- data_width, 8: RAM word width; pixel format RGB332 (r=[7:5], g=[4:2], b=[1:0]).
- FB_W_LOG2, 5 / FB_H_LOG2, 5: frame-buffer width/height log2.
- SCALE_SHIFT, 4: each buffer pixel covers 2^SCALE_SHIFT x 2^SCALE_SHIFT screen pixels.
- H_ACTIVE 640, H_FP 16, H_SYNC 96, H_BP 48; V_ACTIVE 480, V_FP 10, V_SYNC 2, V_BP 33: timing in pixels/lines.
- BORDER, 8'h00: RGB332 colour outside the window.
- clk  in  1  pixel clock (same clock as the RAM read clock).
- rst_n  in  1  asynchronous, active-low reset.
- read_address  out  addr_width  RAM read address; combinational from counter registers only.
- q  in  data_width  RAM read data; valid 2 cycles after read_address.
- blank  in  1  when high, forces rgb to 0 in active video (sampled at output stage).
- hsync_n, vsync_n  out  1  active-low syncs.
- de  out  1  high during active video.
- red, green, blue  out  3/3/2  pixel colour.
- frame_start  out  1  one-cycle pulse aligned with the first active pixel of a frame.

## Operation
- h_cnt 0..H_TOTAL-1 (H_TOTAL=800), v_cnt 0..V_TOTAL-1 (525); v_cnt advances when h_cnt wraps; both wrap to 0 at (799,524).
- Active region: h_cnt<H_ACTIVE and v_cnt<V_ACTIVE. Sync asserted for h_cnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC), likewise vertical.
- fx = h_cnt>>SCALE_SHIFT, fy = v_cnt>>SCALE_SHIFT; in_window = active && fx<2^FB_W_LOG2 && fy<2^FB_H_LOG2.
- read_address = {fy[FB_H_LOG2-1:0], fx[FB_W_LOG2-1:0]}. Out-of-window values are don't-care, but the address must be driven to the truncated value with no X.
- Output colour:
  - inactive -> 0.
  - active && blank -> 0.
  - in_window -> unpacked q.
  - otherwise -> BORDER.
- Reset (async assert): counters to 0; all pipeline stages clear; hsync_n=vsync_n=1, de=0, rgb=0, frame_start=0. Mid-frame reset aborts the frame; after release, scan restarts at (0,0).

## Timing
- Counter state at cycle n -> RAM samples address at edge n+1 -> q valid in cycle n+2 -> output registers load at end of n+2.
- All outputs (hsync_n, vsync_n, de, rgb, frame_start) therefore lag the counters by exactly 3 cycles. Control signals travel through a 3-stage shift pipeline; in_window/active use 2 stages, then the output register.
- After rst_n release, the first de=1 and frame_start=1 appear on the 3rd rising clk edge (counter=(0,0) at the first edge).
- Every output is registered; no combinational path from q or blank to the pins except through the output register.

## Structure
- Package vga_pkg: timing constants, H_TOTAL/V_TOTAL derivation, RGB332 unpack function, default BORDER.
- Sub-module vga_timing: h/v counters plus raw hsync/vsync/active/frame_start generation. The top level adds address mapping, the latency pipeline and the colour mux.

## Test plan
- Free run after reset: hsync_n period 800 clk, low for 96 clk; vsync_n period 420000 clk, low for 1600 clk; de high 640 clk per line on 480 lines.
- Address mapping with behavioural 2-cycle RAM model (mem[a]=a[7:0]): pixel (17,3) -> address 1, rgb from 8'h01; pixel (100,50) -> address 102 (fy=3, fx=6).
- Window/border: with BORDER=8'hE0, pixel x=512 or y>=512 region shows red=7, green=0, blue=0; x=511,y=0 shows mem[31].
- Latency: with mem[0]=8'hFF, the first de-high cycle after reset shows rgb=(7,7,3) exactly 3 edges after release; frame_start is high in the same cycle only.
- blank=1 during active video -> rgb=0 while de and syncs are unchanged; blank=1 during the porch has no effect.
- Reset asserted at line 200, pixel 300: outputs clear immediately (asynchronously); after release, timing restarts and frame_start fires 3 edges later.
